hsid_mse_acc: RTL and testbench

Consumer-side block for the batch squared-difference stream produced by `hsid_mse_batch_*`. It takes one per-word partial sum per valid cycle and accumulates them over one vector of `vctr_len` words. It then divides the total by the element count (2 elements per word) with a sequential divider and presents the mean squared error on a valid/ready output. It sits between the batch MSE datapath and the spectral-ID comparison/argmin logic.

---
 rtl/hsid_mse_pkg.sv | 20 ++
 rtl/hsid_mse_acc_if.sv | 30 +++
 rtl/hsid_div_seq.sv | 75 +++++++
 rtl/hsid_mse_acc.sv | 101 ++++++++++
 tb/tb_hsid_mse_acc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hsid_mse_pkg.sv
// rtl/hsid_mse_pkg.sv - shared types, default widths and width helper for the MSE accumulator
package hsid_mse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DIV,
        DONE
    } mse_acc_state_t;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_DATA_WIDTH_SUM = DEF_DATA_WIDTH * 2;
    localparam int DEF_CNT_WIDTH      = 10;

    // Enough headroom for (2^CNT_WIDTH - 1) maximal sums plus the divider's shifted remainder.
    function automatic int acc_width(input int sum_w, input int cnt_w);
        return sum_w + cnt_w + 2;
    endfunction

endpackage

// File: rtl/hsid_mse_acc_if.sv
// rtl/hsid_mse_acc_if.sv - batch-sum input, length/start control and MSE result handshake
interface hsid_mse_acc_if
    import hsid_mse_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_SUM = DATA_WIDTH * 2,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int ACC_WIDTH      = acc_width(DATA_WIDTH_SUM, CNT_WIDTH)
) ();

    logic                      start;
    logic [CNT_WIDTH-1:0]      vctr_len;
    logic                      sum_valid;
    logic [DATA_WIDTH_SUM-1:0] sum_in;
    logic                      mse_ready;
    logic                      mse_valid;
    logic [ACC_WIDTH-1:0]      mse_out;
    logic                      busy;

    modport master (
        output start, vctr_len, sum_valid, sum_in, mse_ready,
        input  mse_valid, mse_out, busy
    );

    modport slave (
        input  start, vctr_len, sum_valid, sum_in, mse_ready,
        output mse_valid, mse_out, busy
    );

endinterface

// File: rtl/hsid_div_seq.sv
// rtl/hsid_div_seq.sv - restoring divider, one quotient bit per cycle, done pulse on the last bit
module hsid_div_seq
    import hsid_mse_pkg::*;
#(
    parameter int WIDTH = acc_width(DEF_DATA_WIDTH_SUM, DEF_CNT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_sh, diff;

    // Divider state registers; the quotient register starts out holding the dividend and shifts it out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

    // One restoring step: shift in the next dividend bit, keep the subtraction only if it did not borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH);
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/hsid_mse_acc.sv
// rtl/hsid_mse_acc.sv - accumulates per-word squared-difference sums and emits their per-element mean
module hsid_mse_acc
    import hsid_mse_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_SUM = DATA_WIDTH * 2,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int ACC_WIDTH      = acc_width(DATA_WIDTH_SUM, CNT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    hsid_mse_acc_if.slave    bus
);

    mse_acc_state_t       state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] mse_q, mse_d;
    logic [ACC_WIDTH-1:0] sum_ext, dividend, divisor, quotient;
    logic                 acc_take, last_word, div_start, div_done;

    assign sum_ext   = {{(ACC_WIDTH - DATA_WIDTH_SUM){1'b0}}, bus.sum_in};
    assign acc_take  = (state_q == ACC) && bus.sum_valid;
    assign last_word = (cnt_q == len_q - CNT_WIDTH'(1));
    // The divider is loaded on the same edge that accepts the final word, so it sees the finished total.
    assign div_start = acc_take && last_word;
    assign dividend  = acc_q + sum_ext;
    // Two elements per word, so the element count is the word count shifted left once.
    assign divisor   = {{(ACC_WIDTH - CNT_WIDTH - 1){1'b0}}, len_q, 1'b0};

    hsid_div_seq #(
        .WIDTH (ACC_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .done     (div_done),
        .quotient (quotient)
    );

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mse_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mse_q   <= mse_d;
        end
    end

    // Next-state decision: start only in IDLE, result release only in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = (bus.vctr_len == '0) ? DONE : ACC;
            ACC:  if (div_start) state_d = DIV;
            DIV:  if (div_done)  state_d = DONE;
            DONE: if (bus.mse_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: latch length on start, accumulate valid words, capture the quotient.
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        mse_d = mse_q;
        if (state_q == IDLE && bus.start) begin
            len_d = bus.vctr_len;
            cnt_d = '0;
            acc_d = '0;
            if (bus.vctr_len == '0) begin
                mse_d = '0;
            end
        end else if (acc_take) begin
            acc_d = acc_q + sum_ext;
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (state_q == DIV && div_done) begin
            mse_d = quotient;
        end
    end

    // Outputs decoded straight from registers so reset clears them without waiting for a clock.
    always_comb begin
        bus.mse_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.mse_out   = mse_q;
    end

endmodule

// File: tb/tb_hsid_mse_acc.sv
// tb/tb_hsid_mse_acc.sv - table, hand-written and randomized checks of hsid_mse_acc against a plain arithmetic model
module tb_hsid_mse_acc;
    import hsid_mse_pkg::*;

    // A word carries two squared 16-bit differences, whose sum needs 33 bits.
    localparam int DW = 16;
    localparam int SW = 33;
    localparam int CW = 10;
    localparam int AW = acc_width(SW, CW);

    typedef struct {
        int            len;
        logic [SW-1:0] s0;
        logic [SW-1:0] inc;
        int            gap;
        int            hold;
        logic [AW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hsid_mse_acc_if #(
        .DATA_WIDTH(DW), .DATA_WIDTH_SUM(SW), .CNT_WIDTH(CW), .ACC_WIDTH(AW)
    ) bus ();

    hsid_mse_acc #(
        .DATA_WIDTH(DW), .DATA_WIDTH_SUM(SW), .CNT_WIDTH(CW), .ACC_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            total_n = 0;
    int            bad_n   = 0;
    logic [SW-1:0] sq[$];
    int            gq[$];
    vec_t          tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector from sq/gq, checks latency and result, then holds for 'hold' cycles and releases.
    task automatic run_vec(input string name, input int len, input logic [63:0] exp, input int hold);
        int            n;
        logic [AW-1:0] held;
        bus.vctr_len = CW'(len);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.vctr_len = CW'($urandom);
        if (len == 0) begin
            chk({name, " zero-len valid"}, 64'(bus.mse_valid), 64'd1);
        end else begin
            chk({name, " busy"}, 64'(bus.busy), 64'd1);
            for (int i = 0; i < len; i++) begin
                repeat (gq[i]) begin
                    bus.sum_valid = 1'b0;
                    bus.sum_in    = SW'({$urandom, $urandom});
                    bus.start     = 1'($urandom_range(0, 1));
                    bus.vctr_len  = CW'($urandom);
                    tick();
                end
                bus.start     = 1'b0;
                bus.sum_valid = 1'b1;
                bus.sum_in    = sq[i];
                tick();
            end
            bus.sum_valid = 1'b0;
            n = 0;
            while (!bus.mse_valid && n < AW + 20) begin
                bus.sum_valid = 1'($urandom_range(0, 1));
                bus.start     = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            bus.sum_valid = 1'b0;
            bus.start     = 1'b0;
            chk({name, " latency"}, 64'(n), 64'(AW + 1));
        end
        chk({name, " mse_out"}, 64'(bus.mse_out), exp);
        held = bus.mse_out;
        for (int k = 0; k < hold; k++) begin
            bus.start    = (k == 2);
            bus.vctr_len = '0;
            tick();
            chk({name, " held valid"}, 64'(bus.mse_valid), 64'd1);
            chk({name, " held out"}, 64'(bus.mse_out), 64'(held));
        end
        bus.start     = 1'b0;
        bus.mse_ready = 1'b1;
        tick();
        bus.mse_ready = 1'b0;
        chk({name, " released"}, 64'({bus.mse_valid, bus.busy}), 64'd0);
    endtask

    task automatic fill(input int len, input logic [SW-1:0] s0, input logic [SW-1:0] inc, input int gap);
        sq.delete();
        gq.delete();
        for (int i = 0; i < len; i++) begin
            sq.push_back(s0 + SW'(i) * inc);
            gq.push_back(gap);
        end
    endtask

    initial begin
        longint unsigned tot;
        int              len;

        tbl[0] = '{len: 1,    s0: 33'd100,         inc: 33'd0,  gap: 0, hold: 0, exp: 45'd50};
        tbl[1] = '{len: 4,    s0: 33'd10,          inc: 33'd10, gap: 1, hold: 0, exp: 45'd12};
        tbl[2] = '{len: 0,    s0: 33'd0,           inc: 33'd0,  gap: 0, hold: 0, exp: 45'd0};
        tbl[3] = '{len: 2,    s0: 33'd3,           inc: 33'd2,  gap: 0, hold: 5, exp: 45'd2};
        tbl[4] = '{len: 3,    s0: 33'd7,           inc: 33'd0,  gap: 2, hold: 0, exp: 45'd3};
        tbl[5] = '{len: 2,    s0: 33'd5,           inc: 33'd0,  gap: 0, hold: 0, exp: 45'd2};
        tbl[6] = '{len: 1023, s0: 33'h1_FFFC_0002, inc: 33'd0,  gap: 0, hold: 0, exp: 45'hFFFE_0001};

        bus.start     = 1'b0;
        bus.vctr_len  = '0;
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        bus.mse_ready = 1'b0;

        repeat (3) tick();
        chk("reset mse_valid", 64'(bus.mse_valid), 64'd0);
        chk("reset mse_out", 64'(bus.mse_out), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        repeat (3) begin
            bus.sum_valid = 1'b1;
            bus.sum_in    = SW'(999);
            tick();
        end
        bus.sum_valid = 1'b0;
        chk("idle sum_valid ignored", 64'(bus.busy), 64'd0);

        foreach (tbl[i]) begin
            fill(tbl[i].len, tbl[i].s0, tbl[i].inc, tbl[i].gap);
            run_vec($sformatf("tbl%0d", i), tbl[i].len, 64'(tbl[i].exp), tbl[i].hold);
        end

        // Start alongside the releasing handshake must wait one cycle.
        bus.vctr_len = '0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        chk("hs zero-len valid", 64'(bus.mse_valid), 64'd1);
        bus.mse_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.mse_ready = 1'b0;
        chk("hs start not absorbed", 64'({bus.mse_valid, bus.busy}), 64'd0);
        tick();
        bus.start = 1'b0;
        chk("hs start next cycle", 64'(bus.mse_valid), 64'd1);
        bus.mse_ready = 1'b1;
        tick();
        bus.mse_ready = 1'b0;
        chk("hs release", 64'(bus.mse_valid), 64'd0);

        // Reset in the middle of the division.
        fill(1, 33'd100, 33'd0, 0);
        run_vec("pre-reset", 1, 64'd50, 0);
        bus.vctr_len = CW'(1);
        bus.start    = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.sum_valid = 1'b1;
        bus.sum_in    = SW'(100);
        tick();
        bus.sum_valid = 1'b0;
        repeat (10) tick();
        chk("mid-div busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", 64'({bus.mse_valid, bus.busy}), 64'd0);
        chk("async reset mse_out", 64'(bus.mse_out), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fill(1, 33'd8, 33'd0, 0);
        run_vec("post-reset", 1, 64'd4, 0);

        // Randomized vectors against the arithmetic model.
        for (int r = 0; r < 25; r++) begin
            len = (r % 8 == 7) ? 0 : $urandom_range(1, 16);
            sq.delete();
            gq.delete();
            tot = 0;
            for (int i = 0; i < len; i++) begin
                sq.push_back(SW'({$urandom, $urandom}));
                gq.push_back($urandom_range(0, 2));
                tot += longint'(sq[i]);
            end
            run_vec($sformatf("rnd%0d", r), len, (len == 0) ? 64'd0 : tot / (2 * longint'(len)),
                    $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
